// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches instruction words from a synchronous program
// memory, decodes them and hands each one to the datapath controller with a
// one-cycle config_en pulse. It then waits for ctrl_done and moves to the next
// address. The program stops on a halt word, the last address, abort or a
// watchdog timeout.
module instruction_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int PC_WIDTH   = 8,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 16,
  localparam int IW        = 3 + 3*ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PC_WIDTH-1:0]   start_pc,
  output logic                  instr_rd_en,
  output logic [PC_WIDTH-1:0]   instr_addr,
  input  logic [IW-1:0]         instr_data,
  input  logic                  ctrl_done,
  output logic                  config_en,
  output logic [1:0]            opcode,
  output logic [ADDR_WIDTH-1:0] op1_base_addr,
  output logic [ADDR_WIDTH-1:0] op2_base_addr,
  output logic [ADDR_WIDTH-1:0] out_base_addr,
  output logic                  busy,
  output logic                  halted,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_ARM, S_WAIT, S_HALT, S_ERR
  } state_t;

  state_t state, next;
  logic [PC_WIDTH-1:0] pc;
  logic [WD_W-1:0]     wdog;
  logic                idle_like;
  logic                launch;
  logic                pc_last;

  // The pc register drives the memory address directly, so it is a flop output.
  assign instr_addr = pc;
  assign idle_like  = (state == S_IDLE) || (state == S_HALT) || (state == S_ERR);
  assign launch     = start && !abort && idle_like;
  assign pc_last    = &pc;

  // Next-state logic. An abort overrides every other transition.
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE, S_HALT, S_ERR: if (start) next = S_FETCH;
      S_FETCH:  next = S_DECODE;
      S_DECODE: next = instr_data[IW-1] ? S_HALT : S_ISSUE;
      S_ISSUE:  next = S_ARM;
      S_ARM:    next = S_WAIT;
      S_WAIT: begin
        if (ctrl_done)          next = pc_last ? S_HALT : S_FETCH;
        else if (wdog == WD_LAST) next = S_ERR;
      end
      default:  next = S_IDLE;
    endcase
    if (abort) next = S_IDLE;
  end

  // State register plus registered outputs. Status flags are decoded from the
  // next state, so they change in the same cycle the new state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pc            <= '0;
      wdog          <= '0;
      instr_rd_en   <= 1'b0;
      config_en     <= 1'b0;
      busy          <= 1'b0;
      halted        <= 1'b0;
      error         <= 1'b0;
      opcode        <= '0;
      op1_base_addr <= '0;
      op2_base_addr <= '0;
      out_base_addr <= '0;
      instr_count   <= '0;
    end else begin
      state       <= next;
      instr_rd_en <= (next == S_FETCH);
      config_en   <= (next == S_ISSUE);
      busy        <= !((next == S_IDLE) || (next == S_HALT) || (next == S_ERR));
      halted      <= (next == S_HALT);
      error       <= (next == S_ERR);
      if (launch) begin
        pc          <= start_pc;
        instr_count <= '0;
      end
      if (!abort) begin
        unique case (state)
          S_DECODE: begin
            opcode        <= instr_data[IW-2:IW-3];
            op1_base_addr <= instr_data[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
            op2_base_addr <= instr_data[2*ADDR_WIDTH-1:ADDR_WIDTH];
            out_base_addr <= instr_data[ADDR_WIDTH-1:0];
          end
          // A done still high from the previous op is ignored here.
          S_ARM: wdog <= '0;
          S_WAIT: begin
            if (ctrl_done) begin
              if (!(&instr_count)) instr_count <= instr_count + CNT_WIDTH'(1);
              // The last address ends the program; the pc never wraps.
              if (!pc_last) pc <= pc + PC_WIDTH'(1);
            end else begin
              wdog <= wdog + WD_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: program memory and controller models,
// issue scoreboard, table of program words, and hand-written corner sequences.
module tb_instruction_sequencer;
  localparam int AW = 10, PW = 8, TO = 16, CW = 16, IW = 3 + 3*AW;

  logic clk = 1'b0;
  logic rst, start, abort, ctrl_done;
  logic [PW-1:0] start_pc, instr_addr;
  logic [IW-1:0] instr_data = '0;
  logic instr_rd_en, config_en, busy, halted, error;
  logic [1:0] opcode;
  logic [AW-1:0] op1_base_addr, op2_base_addr, out_base_addr;
  logic [CW-1:0] instr_count;

  instruction_sequencer #(.ADDR_WIDTH(AW), .PC_WIDTH(PW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .start_pc(start_pc),
    .instr_rd_en(instr_rd_en), .instr_addr(instr_addr), .instr_data(instr_data),
    .ctrl_done(ctrl_done), .config_en(config_en), .opcode(opcode),
    .op1_base_addr(op1_base_addr), .op2_base_addr(op2_base_addr),
    .out_base_addr(out_base_addr), .busy(busy), .halted(halted), .error(error),
    .instr_count(instr_count));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cfg_cnt = 0, fetch0 = 0;
  logic [IW-1:0] prog [256];
  logic [2+3*AW-1:0] sb_q [$];

  // Controller model: done rises done_delay cycles after config_en.
  int  done_delay = 2, dcnt = 0;
  logic model_done = 1'b0, manual = 1'b0, man_done = 1'b0;
  assign ctrl_done = manual ? man_done : model_done;

  typedef struct {
    int addr; logic halt; logic [1:0] op; logic [AW-1:0] a, b, c;
  } vec_t;
  vec_t vtab [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Program memory with one-cycle read latency.
  always @(posedge clk) if (instr_rd_en) instr_data <= prog[instr_addr];

  always @(posedge clk) begin
    #1;
    if (rst) begin
      dcnt = 0; model_done = 1'b0;
    end else if (config_en) begin
      model_done = 1'b0; dcnt = done_delay;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) model_done = 1'b1;
    end
  end

  // Issue scoreboard and fetch monitor.
  always @(negedge clk) begin
    if (instr_rd_en && instr_addr == '0) fetch0++;
    if (config_en) begin
      cfg_cnt++;
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected config_en: fields %0h", {opcode, op1_base_addr, op2_base_addr, out_base_addr});
      end else begin
        chk("issue fields", {opcode, op1_base_addr, op2_base_addr, out_base_addr}, sb_q.pop_front());
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic push(input int i);
    sb_q.push_back({vtab[i].op, vtab[i].a, vtab[i].b, vtab[i].c});
  endtask

  task automatic launch(input logic [PW-1:0] pc);
    start_pc = pc; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (halted || error) break;
      tick();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vtab[0] = '{0,   1'b0, 2'd1, 10'd10,   10'd20,  10'd30};
    vtab[1] = '{1,   1'b0, 2'd3, 10'd40,   10'd50,  10'd60};
    vtab[2] = '{2,   1'b1, 2'd0, 10'd0,    10'd0,   10'd0};
    vtab[3] = '{10,  1'b0, 2'd0, 10'd1,    10'd2,   10'd3};
    vtab[4] = '{11,  1'b1, 2'd2, 10'd9,    10'd9,   10'd9};
    vtab[5] = '{20,  1'b0, 2'd2, 10'd100,  10'd200, 10'd300};
    vtab[6] = '{21,  1'b1, 2'd0, 10'd0,    10'd0,   10'd0};
    vtab[7] = '{255, 1'b0, 2'd1, 10'd1023, 10'd512, 10'd7};
    vtab[8] = '{30,  1'b0, 2'd2, 10'd5,    10'd6,   10'd7};
    vtab[9] = '{40,  1'b0, 2'd3, 10'd11,   10'd22,  10'd33};
    for (int i = 0; i < 256; i++) prog[i] = '0;
    for (int i = 0; i < 10; i++)
      prog[vtab[i].addr] = {vtab[i].halt, vtab[i].op, vtab[i].a, vtab[i].b, vtab[i].c};

    rst = 1'b1; start = 1'b0; abort = 1'b0; start_pc = '0;
    tick(); tick(); tick();
    chk("reset outputs", {instr_rd_en, config_en, busy, halted, error, instr_addr, opcode,
        op1_base_addr, op2_base_addr, out_base_addr, instr_count}, 64'd0);
    rst = 1'b0; tick();

    // Two-instruction program ending on a halt word.
    cfg_cnt = 0;
    for (int i = 0; i < 3; i++) if (!vtab[i].halt) push(i);
    launch(8'd0);
    chk("fetch rd_en/addr/busy", {instr_rd_en, instr_addr, busy}, {1'b1, 8'd0, 1'b1});
    tick(); chk("decode rd_en", instr_rd_en, 1'b0);
    tick(); chk("issue config_en", config_en, 1'b1);
    tick(); chk("arm config_en", config_en, 1'b0);
    wait_end(80);
    chk("prog halted/busy/error", {halted, busy, error}, 3'b100);
    chk("prog count", instr_count, 16'd2);
    chk("prog pulses", cfg_cnt, 2);
    chk("prog sb drained", sb_q.size(), 0);

    // Stale done held through ISSUE/ARM must not advance the program.
    manual = 1'b1; man_done = 1'b1; push(3);
    launch(8'd10); tick(); tick(); tick(); tick();
    man_done = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("stale no advance", {instr_rd_en, busy, instr_count}, {1'b0, 1'b1, 16'd0});
      tick();
    end
    man_done = 1'b1; tick();
    chk("stale advance", {instr_rd_en, instr_addr, instr_count}, {1'b1, 8'd11, 16'd1});
    wait_end(40);
    chk("stale halted/count", {halted, instr_count}, {1'b1, 16'd1});
    manual = 1'b0;

    // Watchdog: no done at all.
    done_delay = -1; push(5);
    launch(8'd20); tick(); tick(); tick();
    for (int j = 0; j < TO; j++) begin
      tick(); chk("wd still waiting", {busy, error}, 2'b10);
    end
    tick(); chk("wd error/busy", {error, busy}, 2'b10);
    done_delay = 2; push(5);
    launch(8'd20);
    chk("wd restart", {error, instr_rd_en, instr_count}, {1'b0, 1'b1, 16'd0});
    wait_end(40);
    chk("wd rerun halted/count", {halted, instr_count}, {1'b1, 16'd1});

    // Last address ends the program without fetching address 0.
    fetch0 = 0; push(7);
    launch(8'd255);
    wait_end(40);
    chk("end halted/count", {halted, busy, instr_count}, {1'b1, 1'b0, 16'd1});
    chk("end no fetch of 0", fetch0, 0);
    chk("end sb drained", sb_q.size(), 0);

    // Abort and start together in WAIT.
    done_delay = -1; cfg_cnt = 0; push(8);
    launch(8'd30); tick(); tick(); tick(); tick();
    chk("abort pre busy", busy, 1'b1);
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("abort state", {busy, instr_rd_en, config_en, halted, error}, 5'b00000);
    chk("abort holds op1", op1_base_addr, vtab[8].a);
    chk("abort holds count", instr_count, 16'd0);
    repeat (4) tick();
    chk("abort start ignored", {busy, instr_rd_en}, 2'b00);
    chk("abort pulses", cfg_cnt, 1);

    // Reset while in ISSUE.
    done_delay = 2; push(9);
    launch(8'd40); tick(); tick();
    chk("rst pre issue", config_en, 1'b1);
    rst = 1'b1; tick();
    chk("rst mid outputs", {instr_rd_en, config_en, busy, halted, error, instr_addr, opcode,
        op1_base_addr, op2_base_addr, out_base_addr, instr_count}, 64'd0);
    rst = 1'b0; tick(); tick();
    chk("rst stays idle", {busy, config_en, instr_rd_en}, 3'b000);
    chk("final sb drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
